// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//
// Collects press events (and optionally long-press events) from a bank of
// debounced buttons. Each event is held in a per-button flag until a
// round-robin arbiter hands it to a single valid/ready event port. Also
// generates the shared tick pulse that the upstream debouncers use.
//
// Handshake: evt_valid rises with evt_id/evt_long stable. All three stay
// unchanged until a clock edge where evt_valid && evt_ready, which completes
// the transfer. evt_ready is ignored while evt_valid is low.
//
// Optional feature: define BUTTON_LONG_PRESS_EN to enable long-press
// detection with per-button hold counters. Without it, evt_long is tied to 0.
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset      asynchronous, active-high
//   btn_db     debounced button levels, 1 = pressed
//   evt_ready  consumer accepts the presented event
//   ovf_clr    synchronous clear of the sticky overflow flag
//   tick       one-clock pulse every 2^TICK_BITS clocks
//   evt_valid  event present
//   evt_id     index of the button that caused the event
//   evt_long   1 = long-press event, 0 = press event
//   pending    per-button OR of the queued press/long flags
//   overflow   sticky flag, set when an event is lost
module button_event_arbiter #(
    parameter int NUM_BTN    = 4,
    parameter int TICK_BITS  = 19,
    parameter int LONG_TICKS = 100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_db,
    input  logic               evt_ready,
    input  logic               ovf_clr,
    output logic               tick,
    output logic               evt_valid,
    output logic [2:0]         evt_id,
    output logic               evt_long,
    output logic [NUM_BTN-1:0] pending,
    output logic               overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state, state_next;

    // Shared tick prescaler
    logic [TICK_BITS-1:0] presc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) presc <= '0;
        else       presc <= presc + 1'b1;
    end

    assign tick = &presc;

    // Edge detection. On the first clock after reset both registers load
    // from btn_db, so a button already held at reset release gives no edge.
    logic               edge_armed;
    logic [NUM_BTN-1:0] btn_q, btn_prev, rise;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            edge_armed <= 1'b0;
            btn_q      <= '0;
            btn_prev   <= '0;
        end else begin
            edge_armed <= 1'b1;
            btn_q      <= btn_db;
            btn_prev   <= edge_armed ? btn_q : btn_db;
        end
    end

    assign rise = btn_q & ~btn_prev;

    // Event flags and arbitration signals
    logic [NUM_BTN-1:0] press_flag, req, grant_onehot, clr_press;
    logic [2:0]         last_grant, rr_idx;
    logic               rr_found, grant_en, grant_long, sel_press, ovf_set;

`ifdef BUTTON_LONG_PRESS_EN
    logic [7:0]         hold_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] long_flag, long_hit, clr_long;
    logic               evt_long_q;

    // Hold counters: cleared while released, count ticks while held and
    // stop at LONG_TICKS so only one long event is raised per hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!btn_q[i])
                    hold_cnt[i] <= '0;
                else if (tick && hold_cnt[i] != 8'(LONG_TICKS))
                    hold_cnt[i] <= hold_cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        long_hit = '0;
        for (int i = 0; i < NUM_BTN; i++)
            long_hit[i] = btn_q[i] && tick && (hold_cnt[i] == 8'(LONG_TICKS - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) long_flag <= '0;
        else       long_flag <= (long_flag & ~clr_long) | long_hit;
    end

    assign req       = press_flag | long_flag;
    // Press is reported first; a long-only request is reported as long.
    assign grant_long = ~sel_press;
    assign clr_long  = (grant_en && grant_long) ? grant_onehot : '0;
    // A new event is lost only when its flag is set and not being granted.
    assign ovf_set   = |(rise & press_flag & ~clr_press) |
                       |(long_hit & long_flag & ~clr_long);
    assign evt_long  = evt_long_q;
`else
    assign req        = press_flag;
    assign grant_long = 1'b0;
    assign ovf_set    = |(rise & press_flag & ~clr_press);
    assign evt_long   = 1'b0;
`endif

    // Round-robin pick: first request above last_grant, else wrap to the
    // lowest request.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!rr_found && req[i] && 3'(i) > last_grant) begin
                rr_found = 1'b1;
                rr_idx   = 3'(i);
            end
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!rr_found && req[i]) begin
                rr_found = 1'b1;
                rr_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NUM_BTN; i++)
            grant_onehot[i] = rr_found && (rr_idx == 3'(i));
    end

    assign sel_press = |(press_flag & grant_onehot);
    assign clr_press = (grant_en && !grant_long) ? grant_onehot : '0;

    // FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_en   = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (evt_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign evt_valid = (state == VALID);

    // Event registers and flag state. A rise coinciding with a grant of
    // the same flag re-sets it, so the new press is queued, not lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_flag <= '0;
            overflow   <= 1'b0;
            evt_id     <= '0;
            last_grant <= 3'(NUM_BTN - 1);
`ifdef BUTTON_LONG_PRESS_EN
            evt_long_q <= 1'b0;
`endif
        end else begin
            press_flag <= (press_flag & ~clr_press) | rise;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (grant_en) begin
                evt_id     <= rr_idx;
                last_grant <= rr_idx;
`ifdef BUTTON_LONG_PRESS_EN
                evt_long_q <= grant_long;
`endif
            end
        end
    end

    assign pending = req;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL provide parameter NUM_BTN, default 4, number of debounced button inputs (2..8).
REQ-002 SHALL provide parameter TICK_BITS, default 19, shared tick prescaler width (one tick per 2^TICK_BITS clocks, about 10 ms).
REQ-003 SHALL provide parameter LONG_TICKS, default 100, number of ticks held that defines a long press (1..255).
REQ-004 SHALL have ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- btn_db  in  NUM_BTN  debounced button levels, 1 = pressed
- evt_ready  in  1  consumer accepts event
- ovf_clr  in  1  synchronous clear of overflow
- tick  out  1  one-clock shared pulse for the debouncers
- evt_valid  out  1  event present
- evt_id  out  3  index of the button that caused the event
- evt_long  out  1  1 = long-press event, 0 = press event
- pending  out  NUM_BTN  per-button OR of the queued press and long flags
- overflow  out  1  sticky event-lost flag

Function
REQ-005 SHALL run a free-running TICK_BITS counter and assert tick for one clock when all of its bits are 1.
REQ-006 SHALL register btn_db once and detect rising edges from the registered copy, so a press is seen 2 clocks after btn_db rises.
REQ-007 SHALL set the button's press flag on a rising edge.
REQ-008 SHALL set overflow and drop the new event if the press flag is already set; the queued event is kept.
REQ-009 SHALL keep the press flag set when a rising edge and a grant of the same flag occur in the same cycle, and SHALL NOT set overflow.
REQ-010 SHALL form the request vector req[i] = press[i] | long[i].
REQ-011 SHALL grant round-robin, searching from last_grant+1 modulo NUM_BTN.
REQ-012 SHALL report a press before a long press when both flags of the granted button are set, clearing only the reported flag.
REQ-013 SHALL use a two-state FSM:
- IDLE: if req is nonzero, load evt_id and evt_long, clear the granted flag, update last_grant, go to VALID; evt_valid rises 1 clock after req is seen.
- VALID: hold evt_valid, evt_id and evt_long stable; on evt_ready go to IDLE.
- Sustained throughput is at most one event per 2 clocks.
REQ-014 SHALL ignore evt_ready while in IDLE.
REQ-015 SHALL clear overflow on ovf_clr unless an overflow occurs in the same cycle; setting overflow wins.

Reset
REQ-016 SHALL, on reset, clear the prescaler, edge registers, all flags, hold counters, overflow and evt_valid, set evt_id and evt_long to 0, set the FSM to IDLE and set last_grant to NUM_BTN-1, so button 0 has first priority.
REQ-017 SHALL, when reset is asserted while in VALID, drop the presented event immediately with no handshake.
REQ-018 SHALL NOT record any press for a button already high when reset releases, because the edge register loads from btn_db after the first clock.

Configuration
REQ-019 SHALL implement long-press detection only when macro BUTTON_LONG_PRESS_EN is defined:
- Each button has an 8-bit hold counter.
- The counter clears while its registered level is 0.
- The counter increments on tick while the level is 1 and saturates at LONG_TICKS.
- The long flag is set in the cycle the counter reaches LONG_TICKS, so there is one long event per hold.
- Overflow rules match REQ-008 and REQ-009.
REQ-020 SHALL, without BUTTON_LONG_PRESS_EN, omit the hold counters and long flags, tie evt_long to 0, and make req equal to the press flags.

Verification
REQ-021 Pulse btn_db[2] 0->1 with evt_ready=1 -> evt_valid=1 with evt_id=2 and evt_long=0 3 clocks after the edge; evt_valid=0 on the next clock.
REQ-022 Raise btn_db[0], btn_db[1] and btn_db[3] in the same clock with evt_ready=1 after reset -> events evt_id 0, 1, 3 in order, 2 clocks apart.
REQ-023 Hold evt_ready=0, give button 1 two separate rising edges -> overflow=1, only one event for button 1, and after ovf_clr=1 for one clock overflow=0.
REQ-024 With BUTTON_LONG_PRESS_EN defined, TICK_BITS=4 and LONG_TICKS=3, hold btn_db[1] for 80 clocks -> a press event for id 1, then exactly one event with evt_id=1 and evt_long=1 after the third tick.
REQ-025 Assert reset while evt_valid=1 and evt_ready=0 -> evt_valid=0, pending=0 and tick=0 immediately, with no event after reset release while btn_db is held.
